imem_loader: RTL and testbench

- Writer side of the byte-wide, big-endian instruction memory. It takes 32-bit instruction words over a valid/ready stream and writes each word as 4 consecutive byte writes, MSB at the lowest address.
- Sits between a boot/host source (UART bridge, testbench) and the instruction memory write port. It fills program memory before the datapath fetches from it.
- The read side assembles a word as {mem[a], mem[a+1], mem[a+2], mem[a+3]}, and this block is the exact inverse.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Word stream in and byte write port out for the instruction memory loader.
`timescale 1ns/1ps
interface imem_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;

    modport master (
        output in_valid,
        output in_word,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  in_valid,
        input  in_word,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/imem_loader.sv
// Splits 32-bit words into big-endian byte writes for instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to keep a running sum of written words.
`timescale 1ns/1ps
module imem_loader #(
    parameter int MEM_BYTES = 512,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    imem_loader_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [31:0] LAST_OK = 32'(MEM_BYTES - 4);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_ptr;
    logic [CNT_W-1:0] r_left;
    logic [1:0]       r_beat;
    logic [31:0]      r_word;
    logic             r_error;

    logic             w_accept;
    logic             w_ovf;
    logic             w_misalign;
    logic             w_in_ready;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [7:0]       w_data;
    logic             w_busy;
    logic             w_done;

    assign w_accept   = (r_state == S_LOAD) && bus.in_valid;
    assign w_ovf      = r_ptr > LAST_OK;
    assign w_misalign = |base_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_misalign || (word_count == '0)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_next = w_ovf ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_beat == 2'd3) begin
                    w_next = (r_left == CNT_W'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_left  <= '0;
            r_beat  <= '0;
            r_word  <= '0;
            r_error <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr   <= base_addr;
                        r_left  <= word_count;
                        r_error <= w_misalign;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_ovf) begin
                            r_error <= 1'b1;
                        end else begin
                            r_word <= bus.in_word;
                            r_beat <= 2'd0;
                        end
                    end
                end
                S_WRITE: begin
                    r_ptr  <= r_ptr + 32'd1;
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_left <= r_left - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_sum <= '0;
        end else if (w_accept && !w_ovf) begin
            r_sum <= r_sum + bus.in_word;
        end
    end

    assign checksum = r_sum;
`else
    assign checksum = 32'h0;
`endif

    always_comb begin
        w_in_ready = 1'b0;
        w_we       = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
            end
            S_WRITE: begin
                w_we   = 1'b1;
                w_addr = r_ptr;
                unique case (r_beat)
                    2'd0:    w_data = r_word[31:24];
                    2'd1:    w_data = r_word[23:16];
                    2'd2:    w_data = r_word[15:8];
                    default: w_data = r_word[7:0];
                endcase
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = w_in_ready;
    assign bus.mem_we   = w_we;
    assign bus.mem_addr = w_addr;
    assign bus.mem_data = w_data;
    assign busy         = w_busy;
    assign done         = w_done;
    assign error        = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte order, stalls, overflow, reset, start-while-busy.
`timescale 1ns/1ps
module tb_imem_loader;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [9:0]  word_count;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    imem_loader_if bus ();

    imem_loader #(.MEM_BYTES(512), .CNT_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int fails;
    logic [7:0] mem [0:511];
    int wr_cnt;
    int done_cnt;
    int hi_cnt;
    int cyc;
    int first_cyc;
    int last_cyc;
    logic [31:0] first_addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [31:0] SUM2 = 32'h01F25846;
    localparam logic [31:0] SUMO = 32'h11223344;
`else
    localparam logic [31:0] SUM2 = 32'h0;
    localparam logic [31:0] SUMO = 32'h0;
`endif

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) done_cnt = done_cnt + 1;
        if (bus.mem_we) begin
            if (wr_cnt == 0) begin
                first_cyc  = cyc;
                first_addr = bus.mem_addr;
            end
            last_cyc = cyc;
            wr_cnt   = wr_cnt + 1;
            if (bus.mem_addr > 32'd511) hi_cnt = hi_cnt + 1;
            else mem[bus.mem_addr[8:0]] = bus.mem_data;
        end
    end

    task automatic clr();
        for (int i = 0; i < 512; i++) mem[i] = 8'hEE;
        wr_cnt   = 0;
        done_cnt = 0;
        hi_cnt   = 0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [9:0] c);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            $display("FAIL send_timeout got=no_ready exp=ready");
            fails++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_word  = 32'hBAD0BAD0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            $display("FAIL done_timeout got=no_done exp=done");
            fails++;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.mem_we, busy, done, error} !== 5'b0) begin
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.in_ready, bus.mem_we, busy, done, error});
            fails++;
        end
        checks++;
        if ({bus.mem_addr, bus.mem_data, checksum} !== 72'h0) begin
            $display("FAIL reset_data got=%h %h %h exp=0",
                     bus.mem_addr, bus.mem_data, checksum);
            fails++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clr();
        do_start(32'd0, 10'd1);
        send_word(32'h0001A020);
        wait_done();
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h0001A020) begin
            $display("FAIL basic_bytes got=%h exp=0001a020",
                     {mem[0], mem[1], mem[2], mem[3]});
            fails++;
        end
        checks++;
        if (wr_cnt != 4 || last_cyc - first_cyc != 3) begin
            $display("FAIL basic_writes got=%0d span=%0d exp=4 span=3",
                     wr_cnt, last_cyc - first_cyc);
            fails++;
        end
        checks++;
        if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_done got=%0d err=%b busy=%b exp=1 0 0",
                     done_cnt, error, busy);
            fails++;
        end
    endtask

    task automatic test_stall();
        int n;
        int bad;
        clr();
        do_start(32'd4, 10'd2);
        send_word(32'h00A6A822);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bad = (n >= 20) ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL stall_hold got=%0d exp=0", bad);
            fails++;
        end
        send_word(32'h014BB024);
        wait_done();
        checks++;
        if ({mem[4], mem[5], mem[6], mem[7], mem[8], mem[9], mem[10], mem[11]}
            !== 64'h00A6A822014BB024) begin
            $display("FAIL stall_bytes got=%h exp=00a6a822014bb024",
                     {mem[4], mem[5], mem[6], mem[7],
                      mem[8], mem[9], mem[10], mem[11]});
            fails++;
        end
        checks++;
        if (wr_cnt != 8 || done_cnt != 1 || error !== 1'b0) begin
            $display("FAIL stall_count got=%0d %0d %b exp=8 1 0",
                     wr_cnt, done_cnt, error);
            fails++;
        end
        checks++;
        if (checksum !== SUM2) begin
            $display("FAIL stall_checksum got=%h exp=%h", checksum, SUM2);
            fails++;
        end
    endtask

    task automatic test_overflow();
        clr();
        do_start(32'd508, 10'd2);
        send_word(32'h11223344);
        send_word(32'hDEADBEEF);
        wait_done();
        checks++;
        if ({mem[508], mem[509], mem[510], mem[511]} !== 32'h11223344) begin
            $display("FAIL ovf_bytes got=%h exp=11223344",
                     {mem[508], mem[509], mem[510], mem[511]});
            fails++;
        end
        checks++;
        if (wr_cnt != 4 || hi_cnt != 0) begin
            $display("FAIL ovf_writes got=%0d hi=%0d exp=4 hi=0", wr_cnt, hi_cnt);
            fails++;
        end
        checks++;
        if (error !== 1'b1 || done_cnt != 1) begin
            $display("FAIL ovf_error got=%b %0d exp=1 1", error, done_cnt);
            fails++;
        end
        checks++;
        if (checksum !== SUMO) begin
            $display("FAIL ovf_checksum got=%h exp=%h", checksum, SUMO);
            fails++;
        end
    endtask

    task automatic test_misalign_empty();
        clr();
        do_start(32'd2, 10'd3);
        checks++;
        if ({done, error, bus.in_ready, bus.mem_we} !== 4'b1100) begin
            $display("FAIL mis_done got=%b exp=1100",
                     {done, error, bus.in_ready, bus.mem_we});
            fails++;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_cnt != 0) begin
            $display("FAIL mis_after got=%b %b %0d exp=0 0 0", done, busy, wr_cnt);
            fails++;
        end
        do_start(32'd0, 10'd0);
        checks++;
        if ({done, error, bus.in_ready} !== 3'b100) begin
            $display("FAIL empty_done got=%b exp=100", {done, error, bus.in_ready});
            fails++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_cnt != 0 || done_cnt != 2) begin
            $display("FAIL empty_after got=%b %0d %0d exp=0 0 2",
                     busy, wr_cnt, done_cnt);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        clr();
        do_start(32'd0, 10'd1);
        send_word(32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rstmid_stop got=%b %b exp=0 0", bus.mem_we, busy);
            fails++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_cnt != 2 || mem[2] !== 8'hEE) begin
            $display("FAIL rstmid_partial got=%0d %h exp=2 ee", wr_cnt, mem[2]);
            fails++;
        end
        clr();
        do_start(32'd0, 10'd1);
        send_word(32'h01020304);
        wait_done();
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h01020304 || wr_cnt != 4) begin
            $display("FAIL rstmid_reload got=%h %0d exp=01020304 4",
                     {mem[0], mem[1], mem[2], mem[3]}, wr_cnt);
            fails++;
        end
    endtask

    task automatic test_start_busy();
        clr();
        do_start(32'd16, 10'd1);
        do_start(32'd100, 10'd5);
        send_word(32'hA5A55A5A);
        wait_done();
        checks++;
        if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hA5A55A5A) begin
            $display("FAIL busy_bytes got=%h exp=a5a55a5a",
                     {mem[16], mem[17], mem[18], mem[19]});
            fails++;
        end
        checks++;
        if (wr_cnt != 4 || first_addr !== 32'd16 || mem[100] !== 8'hEE) begin
            $display("FAIL busy_ignore got=%0d %0d %h exp=4 16 ee",
                     wr_cnt, first_addr, mem[100]);
            fails++;
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            $display("FAIL busy_done got=%0d %b exp=1 0", done_cnt, busy);
            fails++;
        end
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        cyc          = 0;
        first_cyc    = 0;
        last_cyc     = 0;
        first_addr   = '0;
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        word_count   = '0;
        bus.in_valid = 1'b0;
        bus.in_word  = '0;
        clr();
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_misalign_empty();
        test_reset_mid();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
